// File: rtl/lsu_pw.sv
// rtl/lsu_pw.sv - posted-write load/store unit with in-order write buffer and bus timeout
module lsu_pw #(
   parameter int DW       = 8,
   parameter int AW       = 16,
   parameter int WB_DEPTH = 4,
   parameter int TO_CYC   = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_read,
   input  logic                        mem_write,
   input  logic [AW-1:0]               addr_in,
   input  logic [DW-1:0]               ds1_data,
   output logic                        mem_ok,
   output logic [DW-1:0]               lsu_out,
   output logic                        bus_err,
   output logic                        wb_empty,
   output logic [$clog2(WB_DEPTH):0]   wb_level,
   output logic [AW-1:0]               addr,
   output logic [DW-1:0]               wdata,
   input  logic [DW-1:0]               rdata,
   output logic                        write,
   output logic                        read,
   input  logic                        rdy
);

   localparam int PW = $clog2(WB_DEPTH);
   localparam int LW = PW + 1;
   localparam int TW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);

   typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   lsu_q, lsu_d;
   logic            write_q, write_d;
   logic            read_q, read_d;
   logic            bus_err_q, bus_err_d;
   logic            rd_ok_q, rd_ok_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [AW-1:0]   wb_addr_q [WB_DEPTH];
   logic [DW-1:0]   wb_data_q [WB_DEPTH];

   logic full, push, pop, strobe, abort;

   // Full is judged on the registered level, so a pop never makes room for a same-cycle push.
   assign full   = (cnt_q == LW'(WB_DEPTH));
   assign push   = mem_write & ~full;
   assign rd_nxt = rd_ptr_q + PW'(1);
   assign strobe = write_q | read_q;
   assign abort  = (TO_CYC != 0) && strobe && !rdy && (tcnt_q == TW'(TO_CYC - 1));

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      read_d    = read_q;
      lsu_d     = lsu_q;
      bus_err_d = 1'b0;
      rd_ok_d   = 1'b0;
      pop       = 1'b0;
      tcnt_d    = '0;
      if (strobe && !rdy && !abort && TO_CYC != 0) tcnt_d = tcnt_q + TW'(1);
      case (state_q)
         IDLE: begin
            // Buffered writes drain before any read starts, so loads see earlier stores.
            if (cnt_q != '0) begin
               state_d = WR;
               addr_d  = wb_addr_q[rd_ptr_q];
               wdata_d = wb_data_q[rd_ptr_q];
               write_d = 1'b1;
            end else if (mem_read && !mem_write && !rd_ok_q) begin
               state_d = RD;
               addr_d  = addr_in;
               read_d  = 1'b1;
            end
         end
         WR: begin
            if (rdy || abort) begin
               pop = 1'b1;
               if (rdy && cnt_q > LW'(1)) begin
                  addr_d  = wb_addr_q[rd_nxt];
                  wdata_d = wb_data_q[rd_nxt];
               end else begin
                  state_d   = IDLE;
                  write_d   = 1'b0;
                  bus_err_d = abort;
               end
            end
         end
         RD: begin
            if (rdy) begin
               lsu_d   = rdata;
               read_d  = 1'b0;
               state_d = RDONE;
            end else if (abort) begin
               lsu_d     = '1;
               read_d    = 1'b0;
               bus_err_d = 1'b1;
               state_d   = RDONE;
            end
         end
         RDONE: begin
            rd_ok_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      cnt_d = cnt_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         lsu_q     <= '0;
         write_q   <= 1'b0;
         read_q    <= 1'b0;
         bus_err_q <= 1'b0;
         rd_ok_q   <= 1'b0;
         tcnt_q    <= '0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         lsu_q     <= lsu_d;
         write_q   <= write_d;
         read_q    <= read_d;
         bus_err_q <= bus_err_d;
         rd_ok_q   <= rd_ok_d;
         tcnt_q    <= tcnt_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_q + PW'(push);
         rd_ptr_q  <= rd_ptr_q + PW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         wb_addr_q[wr_ptr_q] <= addr_in;
         wb_data_q[wr_ptr_q] <= ds1_data;
      end
   end

   assign mem_ok   = push | rd_ok_q;
   assign lsu_out  = lsu_q;
   assign bus_err  = bus_err_q;
   assign wb_empty = (cnt_q == '0);
   assign wb_level = cnt_q;
   assign addr     = addr_q;
   assign wdata    = wdata_q;
   assign write    = write_q;
   assign read     = read_q;

endmodule

// File: tb/tb_lsu_pw.sv
// tb/tb_lsu_pw.sv - directed table and sequence bench for lsu_pw (TO_CYC=4)
module tb_lsu_pw;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [15:0] addr_in;
   logic [7:0]  ds1_data;
   logic        mem_ok;
   logic [7:0]  lsu_out;
   logic        bus_err, wb_empty;
   logic [2:0]  wb_level;
   logic [15:0] addr;
   logic [7:0]  wdata, rdata;
   logic        write, read, rdy;

   int checks = 0;
   int failures = 0;

   logic [7:0]  bus_mem [256];
   logic [15:0] wlog [$];

   lsu_pw #(.DW(8), .AW(16), .WB_DEPTH(4), .TO_CYC(4)) u_dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .addr_in(addr_in), .ds1_data(ds1_data), .mem_ok(mem_ok), .lsu_out(lsu_out),
      .bus_err(bus_err), .wb_empty(wb_empty), .wb_level(wb_level), .addr(addr),
      .wdata(wdata), .rdata(rdata), .write(write), .read(read), .rdy(rdy)
   );

   always #5 clk = ~clk;

   assign rdata = bus_mem[addr[7:0]];

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) bus_mem[i] <= 8'(i) ^ 8'h5A;
      end else if (write && rdy) begin
         bus_mem[addr[7:0]] <= wdata;
         wlog.push_back(addr);
      end
   end

   typedef struct {
      logic        mw;
      logic [15:0] a;
      logic [7:0]  d;
      logic        rdy;
      logic        ok;
      logic        wr;
      logic [15:0] ba;
      logic [7:0]  bd;
      logic [2:0]  lvl;
   } vec_t;

   vec_t tv [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      mem_write = 1'b0;
      mem_read  = 1'b0;
      rdy       = 1'b0;
      repeat (n) next();
   endtask

   task automatic do_load(input logic [15:0] a, input int waits, input bit stuck,
                          output int ok_cyc, output int rd_hi, output int err_cnt,
                          output int err_cyc, output logic [7:0] data);
      ok_cyc = -1; rd_hi = 0; err_cnt = 0; err_cyc = -1; data = 8'h00;
      mem_read = 1'b1;
      addr_in  = a;
      for (int c = 0; c < 30; c++) begin
         if (read) rd_hi++;
         rdy = read && !stuck && (rd_hi > waits);
         @(negedge clk);
         if (bus_err) begin err_cnt++; err_cyc = c; end
         if (mem_ok) begin ok_cyc = c; data = lsu_out; end
         next();
         if (ok_cyc >= 0) break;
      end
      mem_read = 1'b0;
      rdy      = 1'b0;
   endtask

   initial begin
      int ok_c, rh, ec, ecyc, wc, rc, base, wr20, wh;
      logic [7:0] d;
      logic werr;

      tv[0] = '{1'b1, 16'h0010, 8'hA0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 3'd0};
      tv[1] = '{1'b1, 16'h0011, 8'hA1, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 3'd1};
      tv[2] = '{1'b1, 16'h0012, 8'hA2, 1'b0, 1'b1, 1'b1, 16'h0010, 8'hA0, 3'd2};
      tv[3] = '{1'b1, 16'h0013, 8'hA3, 1'b0, 1'b1, 1'b1, 16'h0010, 8'hA0, 3'd3};
      tv[4] = '{1'b1, 16'h0014, 8'hA4, 1'b1, 1'b0, 1'b1, 16'h0010, 8'hA0, 3'd4};
      tv[5] = '{1'b1, 16'h0014, 8'hA4, 1'b1, 1'b1, 1'b1, 16'h0011, 8'hA1, 3'd3};
      tv[6] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0012, 8'hA2, 3'd3};
      tv[7] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0013, 8'hA3, 3'd2};
      tv[8] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0014, 8'hA4, 3'd1};
      tv[9] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 3'd0};

      rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr_in = '0; ds1_data = '0; rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_ok", mem_ok, 0);
      chk("rst_write", write, 0);
      chk("rst_read", read, 0);
      chk("rst_addr", addr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_lsu_out", lsu_out, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_wb_level", wb_level, 0);
      chk("rst_wb_empty", wb_empty, 1);
      @(posedge clk);
      #1 rst = 1'b1;

      base = wlog.size();
      for (int i = 0; i < 10; i++) begin
         mem_write = tv[i].mw;
         addr_in   = tv[i].a;
         ds1_data  = tv[i].d;
         rdy       = tv[i].rdy;
         @(negedge clk);
         chk($sformatf("fill%0d_mem_ok", i), mem_ok, tv[i].ok);
         chk($sformatf("fill%0d_write", i), write, tv[i].wr);
         chk($sformatf("fill%0d_level", i), wb_level, tv[i].lvl);
         chk($sformatf("fill%0d_empty", i), wb_empty, (tv[i].lvl == 3'd0));
         if (tv[i].wr) begin
            chk($sformatf("fill%0d_addr", i), addr, tv[i].ba);
            chk($sformatf("fill%0d_wdata", i), wdata, tv[i].bd);
         end
         next();
      end
      chk("fill_log_size", wlog.size() - base, 5);
      for (int i = 0; i < 5; i++)
         if (base + i < wlog.size())
            chk($sformatf("fill_order%0d", i), wlog[base+i], 16'h0010 + 16'(i));
      idle(2);

      mem_write = 1'b1; addr_in = 16'h0040; ds1_data = 8'hA5; rdy = 1'b1;
      @(negedge clk);
      chk("raw_store_ok", mem_ok, 1);
      next();
      mem_write = 1'b0; mem_read = 1'b1;
      ok_c = -1; wc = -1; rc = -1; d = 8'h00;
      for (int c = 1; c < 20; c++) begin
         if (write && wc < 0) wc = c;
         if (read && rc < 0) rc = c;
         @(negedge clk);
         if (mem_ok) begin ok_c = c; d = lsu_out; end
         next();
         if (ok_c >= 0) break;
      end
      mem_read = 1'b0;
      chk("raw_write_cyc", wc, 2);
      chk("raw_read_cyc", rc, 4);
      chk("raw_mem_ok_cyc", ok_c, 6);
      chk("raw_lsu_out", d, 8'hA5);
      @(negedge clk);
      chk("raw_ok_one_pulse", mem_ok, 0);
      next();
      idle(2);

      do_load(16'h0055, 0, 1'b0, ok_c, rh, ec, ecyc, d);
      chk("ld0_ok_cyc", ok_c, 3);
      chk("ld0_read_cycles", rh, 1);
      chk("ld0_data", d, 8'h0F);
      chk("ld0_no_err", ec, 0);
      idle(2);

      do_load(16'h0066, 3, 1'b0, ok_c, rh, ec, ecyc, d);
      chk("ld3_ok_cyc", ok_c, 6);
      chk("ld3_read_cycles", rh, 4);
      chk("ld3_data", d, 8'h3C);
      chk("ld3_rdy_on_timeout_no_err", ec, 0);
      idle(2);

      do_load(16'h0077, 0, 1'b1, ok_c, rh, ec, ecyc, d);
      chk("ldto_read_cycles", rh, 4);
      chk("ldto_err_count", ec, 1);
      chk("ldto_err_cyc", ecyc, 5);
      chk("ldto_ok_cyc", ok_c, 6);
      chk("ldto_data", d, 8'hFF);
      idle(2);

      base = wlog.size();
      rdy = 1'b0;
      mem_write = 1'b1; addr_in = 16'h0020; ds1_data = 8'hB0;
      next();
      addr_in = 16'h0021; ds1_data = 8'hB1;
      next();
      mem_write = 1'b0;
      wr20 = 0; ec = 0; ecyc = -1; werr = 1'b1;
      for (int c = 2; c < 12; c++) begin
         rdy = write && (addr[7:0] != 8'h20);
         if (write && addr[7:0] == 8'h20) wr20++;
         @(negedge clk);
         if (bus_err) begin ec++; ecyc = c; werr = write; end
         next();
      end
      rdy = 1'b0;
      chk("wto_first_write_cycles", wr20, 4);
      chk("wto_err_count", ec, 1);
      chk("wto_err_cyc", ecyc, 6);
      chk("wto_strobe_low_on_err", werr, 0);
      chk("wto_log_size", wlog.size() - base, 1);
      if (wlog.size() > base) chk("wto_log_addr", wlog[base], 16'h0021);
      chk("wto_second_data", bus_mem[8'h21], 8'hB1);
      chk("wto_first_untouched", bus_mem[8'h20], 8'h7A);
      chk("wto_level", wb_level, 0);

      mem_write = 1'b1; addr_in = 16'h0031; ds1_data = 8'hC1; rdy = 1'b0;
      next();
      mem_write = 1'b0;
      wh = 0; ec = 0;
      for (int c = 1; c < 11; c++) begin
         if (write) wh++;
         rdy = write && (wh >= 4);
         @(negedge clk);
         if (bus_err) ec++;
         next();
      end
      rdy = 1'b0;
      chk("wrdy_to_write_cycles", wh, 4);
      chk("wrdy_to_no_err", ec, 0);
      chk("wrdy_to_data", bus_mem[8'h31], 8'hC1);
      idle(2);

      mem_write = 1'b1; addr_in = 16'h0070; ds1_data = 8'hD0; rdy = 1'b0;
      next();
      mem_write = 1'b0;
      next();
      chk("arst_pre_write", write, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_write", write, 0);
      chk("arst_level", wb_level, 0);
      chk("arst_empty", wb_empty, 1);
      chk("arst_addr", addr, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("arst_post%0d_write", c), write, 0);
         chk($sformatf("arst_post%0d_level", c), wb_level, 0);
         next();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
